// File: rtl/dual_mem_arbiter_pkg.sv
// Shared types for the dual-core memory arbiter: RAM word/status types,
// arbiter FSM state and the registered bus owner.
package dual_mem_arbiter_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic core;
    logic is_data;
  } arb_owner_t;

  // Data class always wins over instruction class when both have a candidate.
  function automatic arb_owner_t pick_owner(input logic d_vld, input logic d_gnt,
                                            input logic i_gnt);
    arb_owner_t o;
    o.core    = d_vld ? d_gnt : i_gnt;
    o.is_data = d_vld;
    return o;
  endfunction

endpackage

// File: rtl/dual_mem_arbiter_if.sv
// Cache-pair and RAM-side signals of the dual-core memory arbiter.
// master: requesters and RAM model; slave: the arbiter.
interface dual_mem_arbiter_if;
  import dual_mem_arbiter_pkg::*;

  logic [1:0]      iREN;
  logic [1:0]      dREN;
  logic [1:0]      dWEN;
  word_t [1:0]     iaddr;
  word_t [1:0]     daddr;
  word_t [1:0]     dstore;
  logic [1:0]      iwait;
  logic [1:0]      dwait;
  word_t [1:0]     iload;
  word_t [1:0]     dload;
  word_t           ramload;
  ramstate_t       ramstate;
  word_t           ramaddr;
  word_t           ramstore;
  logic            ramREN;
  logic            ramWEN;
  logic [1:0]      ccinv;
  word_t [1:0]     ccsnoopaddr;
  logic            bus_err;

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, dwait, iload, dload, ramaddr, ramstore, ramREN, ramWEN,
           ccinv, ccsnoopaddr, bus_err
  );

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, dwait, iload, dload, ramaddr, ramstore, ramREN, ramWEN,
           ccinv, ccsnoopaddr, bus_err
  );

endinterface

// File: rtl/dual_mem_arbiter_rr_select.sv
// Combinational 2-way round-robin picker: with both requesting, the core
// that was not granted last wins.
module dual_mem_arbiter_rr_select (
  input  logic [1:0] req,
  input  logic       rr_last,
  output logic       gnt,
  output logic       valid
);

  always_comb begin
    valid = |req;
    gnt   = 1'b0;
    case (req)
      2'b01:   gnt = 1'b0;
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = ~rr_last;
      default: gnt = 1'b0;
    endcase
  end

endmodule

// File: rtl/dual_mem_arbiter.sv
// Four-requester (2x icache, 2x dcache) arbiter onto one RAM port with
// registered grants. Optional snoop invalidate: DUAL_MEM_SNOOP_INV_EN.
//
// state | meaning
// IDLE  | no owner, RAM outputs 0, waits 1; any request registers an owner
// GRANT | RAM driven from registered owner until ACCESS, drop or timeout
module dual_mem_arbiter
  import dual_mem_arbiter_pkg::*;
#(
  parameter int CPUS        = 2,
  parameter int BUS_TIMEOUT = 0
) (
  input logic               CLK,
  input logic               nRST,
  dual_mem_arbiter_if.slave bus
);

  localparam int          CORE_W  = $clog2(CPUS);
  localparam bit          TO_EN   = (BUS_TIMEOUT > 0);
  localparam logic [31:0] TO_LOAD = TO_EN ? 32'(BUS_TIMEOUT - 1) : 32'd0;

  arb_state_t         state_q, state_d;
  arb_owner_t         owner_q, owner_d;
  logic               rr_last_q;
  logic [31:0]        tmr_q, tmr_d;
  logic               bus_err_q;
  logic [CORE_W-1:0]  oc;
  logic [1:0]         dreq;
  logic               d_gnt, d_vld, i_gnt, i_vld;
  logic               own_req, own_done, timeout_hit;

  assign dreq = bus.dREN | bus.dWEN;
  assign oc   = owner_q.core;

  dual_mem_arbiter_rr_select u_rr_data (
    .req     (dreq),
    .rr_last (rr_last_q),
    .gnt     (d_gnt),
    .valid   (d_vld)
  );

  dual_mem_arbiter_rr_select u_rr_inst (
    .req     (bus.iREN),
    .rr_last (rr_last_q),
    .gnt     (i_gnt),
    .valid   (i_vld)
  );

  assign own_req     = owner_q.is_data ? dreq[oc] : bus.iREN[oc];
  assign own_done    = (state_q == GRANT) && own_req && (bus.ramstate == ACCESS);
  // Timer is a down-counter loaded on grant entry; terminal count 0 in a
  // non-ACCESS cycle ends the grant.
  assign timeout_hit = TO_EN && (state_q == GRANT) && own_req &&
                       (bus.ramstate != ACCESS) && (tmr_q == 32'd0);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      rr_last_q <= 1'b1;
      tmr_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      tmr_q     <= tmr_d;
      bus_err_q <= timeout_hit;
      if (state_q == IDLE && state_d == GRANT) rr_last_q <= owner_d.core;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    tmr_d   = tmr_q;
    case (state_q)
      IDLE: begin
        if (d_vld || i_vld) begin
          state_d = GRANT;
          owner_d = pick_owner(d_vld, d_gnt, i_gnt);
          tmr_d   = TO_LOAD;
        end
      end
      GRANT: begin
        if (!own_req || own_done || timeout_hit) state_d = IDLE;
        else if (tmr_q != 32'd0)                 tmr_d   = tmr_q - 32'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.iwait    = 2'b11;
    bus.dwait    = 2'b11;
    bus.iload    = '0;
    bus.dload    = '0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    if (state_q == GRANT) begin
      if (owner_q.is_data) begin
        bus.dload[oc] = bus.ramload;
        if (own_req) begin
          bus.ramaddr = bus.daddr[oc];
          // A core asserting both enables is treated as a read.
          if (bus.dREN[oc]) begin
            bus.ramREN = 1'b1;
          end else begin
            bus.ramWEN   = 1'b1;
            bus.ramstore = bus.dstore[oc];
          end
        end
        if (own_done) bus.dwait[oc] = 1'b0;
      end else begin
        bus.iload[oc] = bus.ramload;
        if (own_req) begin
          bus.ramaddr = bus.iaddr[oc];
          bus.ramREN  = 1'b1;
        end
        if (own_done) bus.iwait[oc] = 1'b0;
      end
    end
  end

  assign bus.bus_err = bus_err_q;

`ifdef DUAL_MEM_SNOOP_INV_EN
  logic [1:0]  ccinv_q;
  word_t [1:0] snoop_addr_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ccinv_q      <= '0;
      snoop_addr_q <= '0;
    end else begin
      ccinv_q <= '0;
      if (own_done && owner_q.is_data && !bus.dREN[oc]) begin
        ccinv_q[~oc]      <= 1'b1;
        snoop_addr_q[~oc] <= bus.daddr[oc];
      end
    end
  end

  assign bus.ccinv       = ccinv_q;
  assign bus.ccsnoopaddr = snoop_addr_q;
`else
  assign bus.ccinv       = '0;
  assign bus.ccsnoopaddr = '0;
`endif

endmodule

// File: tb/tb_dual_mem_arbiter.sv
// Bench for dual_mem_arbiter: directed scenarios then random traffic, every
// cycle compared against a transaction-level reference model.
module tb_dual_mem_arbiter;
  import dual_mem_arbiter_pkg::*;

  localparam int TO = 4;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  dual_mem_arbiter_if bus ();

  dual_mem_arbiter #(.CPUS(2), .BUS_TIMEOUT(TO)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: who owns the bus, for how long, and pending pulses.
  bit          m_busy;
  int          m_core;
  bit          m_data;
  int          m_rr;
  int          m_age;
  bit          m_err;
  bit [1:0]    m_inv;
  logic [31:0] m_saddr [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_core = 0; m_data = 0; m_rr = 1; m_age = 0; m_err = 0;
    m_inv = '0; m_saddr[0] = '0; m_saddr[1] = '0;
  endtask

  function automatic bit owner_req();
    if (m_data) return (bus.dREN[m_core] | bus.dWEN[m_core]);
    return bus.iREN[m_core];
  endfunction

  function automatic int pick(input bit [1:0] r);
    if (r == 2'b11) return 1 - m_rr;
    return (r == 2'b10) ? 1 : 0;
  endfunction

  task automatic sample();
    logic [31:0] e_addr, e_store;
    logic        e_ren, e_wen, rq, acc;
    logic [1:0]  e_iw, e_dw;
    logic [31:0] e_il [2];
    logic [31:0] e_dl [2];
    @(negedge CLK);
    e_addr = '0; e_store = '0; e_ren = 0; e_wen = 0;
    e_iw = 2'b11; e_dw = 2'b11;
    e_il[0] = '0; e_il[1] = '0; e_dl[0] = '0; e_dl[1] = '0;
    if (m_busy && nRST) begin
      rq  = owner_req();
      acc = (bus.ramstate == ACCESS);
      if (m_data) begin
        e_dl[m_core] = bus.ramload;
        if (rq) begin
          e_addr = bus.daddr[m_core];
          if (bus.dREN[m_core]) e_ren = 1;
          else begin e_wen = 1; e_store = bus.dstore[m_core]; end
        end
        if (rq && acc) e_dw[m_core] = 1'b0;
      end else begin
        e_il[m_core] = bus.ramload;
        if (rq) begin e_addr = bus.iaddr[m_core]; e_ren = 1; end
        if (rq && acc) e_iw[m_core] = 1'b0;
      end
    end
    chk("ramaddr",  bus.ramaddr,  e_addr);
    chk("ramstore", bus.ramstore, e_store);
    chk("ramREN",   32'(bus.ramREN), 32'(e_ren));
    chk("ramWEN",   32'(bus.ramWEN), 32'(e_wen));
    chk("iwait",    32'(bus.iwait),  32'(e_iw));
    chk("dwait",    32'(bus.dwait),  32'(e_dw));
    chk("iload0",   bus.iload[0], e_il[0]);
    chk("iload1",   bus.iload[1], e_il[1]);
    chk("dload0",   bus.dload[0], e_dl[0]);
    chk("dload1",   bus.dload[1], e_dl[1]);
    chk("bus_err",  32'(bus.bus_err), 32'(m_err));
`ifdef DUAL_MEM_SNOOP_INV_EN
    chk("ccinv",    32'(bus.ccinv), 32'(m_inv));
    chk("snoop0",   bus.ccsnoopaddr[0], m_saddr[0]);
    chk("snoop1",   bus.ccsnoopaddr[1], m_saddr[1]);
`else
    chk("ccinv",    32'(bus.ccinv), 32'd0);
    chk("snoop0",   bus.ccsnoopaddr[0], 32'd0);
    chk("snoop1",   bus.ccsnoopaddr[1], 32'd0);
`endif
  endtask

  task automatic advance();
    bit       rq, acc;
    bit [1:0] dr, nxt_inv;
    @(posedge CLK);
    if (!nRST) begin
      model_reset();
    end else begin
      nxt_inv = '0;
      m_err   = 0;
      if (!m_busy) begin
        dr = bus.dREN | bus.dWEN;
        if (dr != 0) begin
          m_data = 1; m_core = pick(dr); m_busy = 1;
        end else if (bus.iREN != 0) begin
          m_data = 0; m_core = pick(bus.iREN); m_busy = 1;
        end
        if (m_busy) begin m_rr = m_core; m_age = 0; end
      end else begin
        rq  = owner_req();
        acc = (bus.ramstate == ACCESS);
        if (!rq) begin
          m_busy = 0;
        end else if (acc) begin
          m_busy = 0;
          if (m_data && !bus.dREN[m_core]) begin
            nxt_inv[1 - m_core] = 1'b1;
            m_saddr[1 - m_core] = bus.daddr[m_core];
          end
        end else begin
          m_age++;
          if (m_age == TO) begin m_busy = 0; m_err = 1; end
        end
      end
      m_inv = nxt_inv;
    end
    #1;
  endtask

  task automatic reset_pulse();
    nRST = 1'b0;
    model_reset();
    sample();
    advance();
    nRST = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ord [$];
    int at  [$];
    int err_cnt, err_cyc, dlow;
    bit [1:0] dlo, ilo;

    bus.iREN = '0; bus.dREN = '0; bus.dWEN = '0;
    bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0;
    bus.ramload = 32'hA5A5_0001; bus.ramstate = FREE;

    // Reset held while all four requesters are asserting.
    nRST = 1'b0; model_reset();
    bus.iREN = 2'b11; bus.dREN = 2'b11;
    #2;
    sample();
    chk("rst_iwait",  32'(bus.iwait),  32'h3);
    chk("rst_dwait",  32'(bus.dwait),  32'h3);
    chk("rst_ramREN", 32'(bus.ramREN), 32'h0);
    chk("rst_ramWEN", 32'(bus.ramWEN), 32'h0);
    chk("rst_buserr", 32'(bus.bus_err), 32'h0);
    advance();
    nRST = 1'b1; bus.dREN = '0; bus.ramstate = ACCESS;
    bus.iaddr[0] = 32'h40; bus.iaddr[1] = 32'h80;
    sample(); advance();
    sample();
    chk("first_gnt_iwait", 32'(bus.iwait), 32'h2);
    chk("first_gnt_addr",  bus.ramaddr, 32'h40);
    advance();
    bus.iREN = '0;
    sample(); advance();

    // Single icache read completing on the second grant cycle.
    bus.iREN = 2'b01; bus.iaddr[0] = 32'h100; bus.ramstate = BUSY;
    bus.ramload = 32'h1234_5678;
    sample(); advance();
    sample(); advance();
    bus.ramstate = ACCESS;
    sample();
    chk("single_addr",  bus.ramaddr, 32'h100);
    chk("single_ren",   32'(bus.ramREN), 32'h1);
    chk("single_iwait", 32'(bus.iwait), 32'h2);
    chk("single_iload", bus.iload[0], 32'h1234_5678);
    advance();
    bus.iREN = '0; bus.ramstate = FREE;
    sample();
    chk("single_after", 32'(bus.iwait), 32'h3);
    advance();

    // Four-way contention; each requester drops once served.
    reset_pulse();
    bus.dREN = 2'b11; bus.iREN = 2'b11; bus.ramstate = ACCESS;
    bus.daddr[0] = 32'h1000; bus.daddr[1] = 32'h2000;
    for (int cyc = 0; cyc < 10; cyc++) begin
      sample();
      dlo = ~bus.dwait; ilo = ~bus.iwait;
      for (int c = 0; c < 2; c++) begin
        if (dlo[c]) begin ord.push_back(c);     at.push_back(cyc); end
        if (ilo[c]) begin ord.push_back(2 + c); at.push_back(cyc); end
      end
      advance();
      bus.dREN = bus.dREN & ~dlo;
      bus.iREN = bus.iREN & ~ilo;
    end
    chk("order_count", 32'(ord.size()), 32'd4);
    if (ord.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("order_who%0d", k), 32'(ord[k]), 32'(k));
        chk($sformatf("order_cyc%0d", k), 32'(at[k]), 32'(2 * k + 1));
      end
    end

    // dcache write by core 1; snoop goes to core 0 when enabled.
    bus.dWEN = 2'b10; bus.daddr[1] = 32'h2F0; bus.dstore[1] = 32'hDEAD_BEEF;
    bus.ramstate = ACCESS;
    sample(); advance();
    sample();
    chk("wr_wen",   32'(bus.ramWEN), 32'h1);
    chk("wr_store", bus.ramstore, 32'hDEAD_BEEF);
    chk("wr_addr",  bus.ramaddr, 32'h2F0);
    chk("wr_dwait", 32'(bus.dwait), 32'h1);
    advance();
    bus.dWEN = '0;
    sample();
`ifdef DUAL_MEM_SNOOP_INV_EN
    chk("snoop_inv",  32'(bus.ccinv), 32'h1);
    chk("snoop_addr", bus.ccsnoopaddr[0], 32'h2F0);
`else
    chk("snoop_inv",  32'(bus.ccinv), 32'h0);
`endif
    advance();

    // Timeout: RAM stays BUSY for the whole grant.
    bus.dREN = 2'b01; bus.daddr[0] = 32'h300; bus.ramstate = BUSY;
    err_cnt = 0; err_cyc = -1; dlow = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      sample();
      if (bus.bus_err === 1'b1) begin err_cnt++; err_cyc = cyc; end
      if (bus.dwait !== 2'b11) dlow++;
      advance();
    end
    chk("to_err_count", 32'(err_cnt), 32'd1);
    chk("to_err_cycle", 32'(err_cyc), 32'd5);
    chk("to_no_dwait",  32'(dlow), 32'd0);
    bus.dREN = '0;
    sample(); advance();
    sample(); advance();

    // Owner drops its request mid-grant; pending icache goes next.
    bus.dREN = 2'b01; bus.iREN = 2'b10; bus.iaddr[1] = 32'h500;
    sample(); advance();
    sample();
    chk("drop_ren_before", 32'(bus.ramREN), 32'h1);
    advance();
    bus.dREN = '0;
    sample();
    chk("drop_ren_after", 32'(bus.ramREN), 32'h0);
    chk("drop_dwait",     32'(bus.dwait), 32'h3);
    advance();
    sample(); advance();
    sample();
    chk("drop_next_addr", bus.ramaddr, 32'h500);
    chk("drop_next_ren",  32'(bus.ramREN), 32'h1);
    advance();
    bus.iREN = '0;
    sample(); advance();

    // Random traffic, including occasional asynchronous resets.
    for (int n = 0; n < 500; n++) begin
      bus.iREN = 2'($urandom_range(0, 3));
      bus.dREN = 2'($urandom_range(0, 3));
      bus.dWEN = 2'($urandom_range(0, 3));
      for (int c = 0; c < 2; c++) begin
        bus.iaddr[c]  = $urandom;
        bus.daddr[c]  = $urandom;
        bus.dstore[c] = $urandom;
      end
      bus.ramload  = $urandom;
      bus.ramstate = ramstate_t'(2'($urandom_range(0, 3)));
      if ($urandom_range(0, 60) == 0) begin
        nRST = 1'b0;
        model_reset();
      end else begin
        nRST = 1'b1;
      end
      sample();
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
